// File: rtl/pipe_controller.sv
// Pipelined control unit: decodes the ID-stage opcode into registered ID/EX controls,
// with hazard bubbles, post-redirect squash, halt drain and call-stack depth checking.
module pipe_controller #(
  parameter int DRAIN_CYCLES = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int STACK_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       halt,
  input  logic       hazard,
  input  logic [4:0] opcode_func,
  input  logic       c_in,
  input  logic       z_in,
  output logic       reg_write_en,
  output logic       mem_write_en,
  output logic       imm_and_mem,
  output logic       ldm,
  output logic       stm,
  output logic       c_write_en,
  output logic       z_write_en,
  output logic [3:0] alu_op,
  output logic       push,
  output logic       pop,
  output logic [1:0] pc_sel,
  output logic       pc_write,
  output logic       flush,
  output logic       busy,
  output logic       done,
  output logic       stack_err
);

  localparam int FW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int SW = $clog2(STACK_DEPTH + 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYCLES);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);
  localparam logic [SW-1:0] DEPTH_MAX  = SW'(STACK_DEPTH);

  typedef enum logic [1:0] {IDLE, STARTING, RUN, DRAIN} state_t;

  state_t        state;
  logic [FW-1:0] flush_cnt;
  logic [DW-1:0] drain_cnt;
  logic [SW-1:0] depth;

  logic       d_regw, d_memw, d_imm, d_ldm, d_stm, d_cw, d_zw;
  logic [3:0] d_alu;
  logic       d_br, d_jmp, d_call, d_ret;

  always_comb begin
    d_regw = 1'b0;
    d_memw = 1'b0;
    d_imm  = 1'b0;
    d_ldm  = 1'b0;
    d_stm  = 1'b0;
    d_cw   = 1'b0;
    d_zw   = 1'b0;
    d_alu  = '0;
    d_br   = 1'b0;
    d_jmp  = 1'b0;
    d_call = 1'b0;
    d_ret  = 1'b0;
    casez (opcode_func)
      5'b00???: begin
        d_alu = {1'b0, opcode_func[2:0]};
        d_regw = 1'b1; d_cw = 1'b1; d_zw = 1'b1;
      end
      5'b01???: begin
        d_alu = {1'b0, opcode_func[2:0]};
        d_regw = 1'b1; d_cw = 1'b1; d_zw = 1'b1; d_imm = 1'b1;
      end
      5'b1100?: begin
        d_alu = {3'b100, opcode_func[0]};
        d_regw = 1'b1; d_cw = 1'b1; d_zw = 1'b1;
      end
      5'b1101?: begin
        d_alu = {3'b101, opcode_func[0]};
        d_regw = 1'b1; d_zw = 1'b1;
      end
      5'b10000: begin d_regw = 1'b1; d_imm = 1'b1; d_ldm = 1'b1; end
      5'b10001: begin d_memw = 1'b1; d_imm = 1'b1; d_stm = 1'b1; end
      5'b10100: d_br = z_in;
      5'b10101: d_br = ~z_in;
      5'b10110: d_br = c_in;
      5'b10111: d_br = ~c_in;
      5'b11100: d_jmp = 1'b1;
      5'b11101: d_call = 1'b1;
      5'b11110: d_ret = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      flush_cnt    <= '0;
      drain_cnt    <= '0;
      depth        <= '0;
      reg_write_en <= 1'b0;
      mem_write_en <= 1'b0;
      imm_and_mem  <= 1'b0;
      ldm          <= 1'b0;
      stm          <= 1'b0;
      c_write_en   <= 1'b0;
      z_write_en   <= 1'b0;
      alu_op       <= '0;
      push         <= 1'b0;
      pop          <= 1'b0;
      pc_sel       <= '0;
      pc_write     <= 1'b0;
      flush        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      stack_err    <= 1'b0;
    end else begin
      reg_write_en <= 1'b0;
      mem_write_en <= 1'b0;
      imm_and_mem  <= 1'b0;
      ldm          <= 1'b0;
      stm          <= 1'b0;
      c_write_en   <= 1'b0;
      z_write_en   <= 1'b0;
      alu_op       <= '0;
      push         <= 1'b0;
      pop          <= 1'b0;
      pc_sel       <= '0;
      pc_write     <= 1'b0;
      flush        <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= STARTING;
            stack_err <= 1'b0;
          end else begin
            busy <= 1'b0;
          end
        end
        STARTING: begin
          if (!start) state <= RUN;
        end
        RUN: begin
          pc_write <= ~hazard | halt | (flush_cnt != '0);
          // A pending squash keeps ticking through the halt cycle so the
          // younger instructions already fetched are still discarded.
          if (halt) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_INIT;
            pc_write  <= 1'b1;
            if (flush_cnt != '0) begin
              flush     <= 1'b1;
              flush_cnt <= flush_cnt - FW'(1);
            end
          end else if (flush_cnt != '0) begin
            flush     <= 1'b1;
            flush_cnt <= flush_cnt - FW'(1);
          end else if (!hazard) begin
            reg_write_en <= d_regw;
            mem_write_en <= d_memw;
            imm_and_mem  <= d_imm;
            ldm          <= d_ldm;
            stm          <= d_stm;
            c_write_en   <= d_cw;
            z_write_en   <= d_zw;
            alu_op       <= d_alu;
            if (d_br || d_jmp) begin
              pc_sel    <= d_br ? 2'd3 : 2'd1;
              flush     <= 1'b1;
              flush_cnt <= FLUSH_INIT;
            end else if (d_call) begin
              if (depth == DEPTH_MAX) begin
                stack_err <= 1'b1;
              end else begin
                push      <= 1'b1;
                pc_sel    <= 2'd1;
                flush     <= 1'b1;
                flush_cnt <= FLUSH_INIT;
                depth     <= depth + SW'(1);
              end
            end else if (d_ret) begin
              if (depth == '0) begin
                stack_err <= 1'b1;
              end else begin
                pop       <= 1'b1;
                pc_sel    <= 2'd2;
                flush     <= 1'b1;
                flush_cnt <= FLUSH_INIT;
                depth     <= depth - SW'(1);
              end
            end
          end
        end
        DRAIN: begin
          if (flush_cnt != '0) begin
            flush     <= 1'b1;
            flush_cnt <= flush_cnt - FW'(1);
          end
          if (drain_cnt == DW'(1)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            flush_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
